// File: rtl/eth_burst_arbiter.sv
// rtl/eth_burst_arbiter.sv - round-robin burst arbiter draining full ADC channel FIFOs into one Ethernet sink
module eth_burst_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int BURST_LEN = 1024,
  parameter int GAP_LEN   = 2048
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_CH-1:0]         full,
  input  logic [NUM_CH-1:0]         empty,
  input  logic                      eth_ready,
  output logic [NUM_CH-1:0]         rd_en,
  output logic                      eth_en,
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic                      sof,
  output logic                      eof,
  output logic                      burst_abort
);

  localparam int SW     = $clog2(NUM_CH);
  localparam int MAXLEN = (BURST_LEN > GAP_LEN) ? BURST_LEN : GAP_LEN;
  localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_LEN - 1);

  typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic [SW-1:0]     last_grant, last_grant_nxt;
  logic [SW-1:0]     ch_sel_nxt;
  logic [SW-1:0]     grant;
  logic              grant_vld;
  logic [NUM_CH-1:0] eligible;

  assign eligible = full & ~empty;

  // Search starts one past the last served channel so every full FIFO gets a turn.
  always_comb begin
    int          idx;
    logic [SW-1:0] idx_s;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    idx_s     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx   = (int'(last_grant) + i) % NUM_CH;
      idx_s = SW'(idx);
      if (!grant_vld && eligible[idx_s]) begin
        grant_vld = 1'b1;
        grant     = idx_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      count      <= '0;
      ch_sel     <= '0;
      last_grant <= SW'(NUM_CH - 1);
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      ch_sel     <= ch_sel_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    ch_sel_nxt     = ch_sel;
    last_grant_nxt = last_grant;
    rd_en          = '0;
    eth_en         = 1'b0;
    sof            = 1'b0;
    eof            = 1'b0;
    burst_abort    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          ch_sel_nxt = grant;
          count_nxt  = '0;
          state_nxt  = READ;
        end
      end
      READ: begin
        // An empty granted FIFO ends the burst even on what would be the last word.
        if (empty[ch_sel]) begin
          burst_abort    = 1'b1;
          state_nxt      = GAP;
          count_nxt      = '0;
          last_grant_nxt = ch_sel;
        end else if (eth_ready) begin
          rd_en[ch_sel] = 1'b1;
          eth_en        = 1'b1;
          sof           = (count == '0);
          eof           = (count == BURST_LAST);
          if (count == BURST_LAST) begin
            state_nxt      = GAP;
            count_nxt      = '0;
            last_grant_nxt = ch_sel;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end
      GAP: begin
        if (count == GAP_LAST) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_burst_arbiter.sv
// tb/tb_eth_burst_arbiter.sv - directed scoreboard bench for eth_burst_arbiter (4 channels, 4-word bursts, 3-cycle gaps)
module tb_eth_burst_arbiter;

  localparam int NUM_CH    = 4;
  localparam int BURST_LEN = 4;
  localparam int GAP_LEN   = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic              eth_ready;
  logic [NUM_CH-1:0] rd_en;
  logic              eth_en;
  logic [1:0]        ch_sel;
  logic              sof;
  logic              eof;
  logic              burst_abort;

  eth_burst_arbiter #(
    .NUM_CH(NUM_CH),
    .BURST_LEN(BURST_LEN),
    .GAP_LEN(GAP_LEN)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .full(full),
    .empty(empty),
    .eth_ready(eth_ready),
    .rd_en(rd_en),
    .eth_en(eth_en),
    .ch_sel(ch_sel),
    .sof(sof),
    .eof(eof),
    .burst_abort(burst_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ab;
    int ch;
    bit sof;
    bit eof;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int ch, input int n);
    for (int k = 0; k < n; k++)
      sb.push_back('{ab: 1'b0, ch: ch, sof: (k == 0), eof: (k == BURST_LEN - 1)});
  endtask

  task automatic push_abort();
    sb.push_back('{ab: 1'b1, ch: 0, sof: 1'b0, eof: 1'b0});
  endtask

  // One char per cycle: B = beat, A = abort pulse, I = quiet (IDLE or GAP).
  task automatic expect_pat(input string tag, input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      @(negedge clk);
      chk($sformatf("%s_en[%0d]", tag, i), 32'(eth_en), 32'(pat[i] == "B"));
      chk($sformatf("%s_ab[%0d]", tag, i), 32'(burst_abort), 32'(pat[i] == "A"));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rstn && (eth_en || burst_abort)) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("ev_abort", 32'(burst_abort), 32'(mon_e.ab));
        if (mon_e.ab) begin
          chk("abort_no_beat", {27'd0, rd_en, eth_en}, 32'd0);
        end else begin
          chk("ch_sel", 32'(ch_sel), 32'(mon_e.ch));
          chk("rd_en_onehot", 32'(rd_en), 32'd1 << mon_e.ch);
          chk("sof", 32'(sof), 32'(mon_e.sof));
          chk("eof", 32'(eof), 32'(mon_e.eof));
        end
      end
    end else if (rstn) begin
      chk("quiet_outputs", {26'd0, rd_en, sof, eof}, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b1;
    full      = '0;
    empty     = '0;
    eth_ready = 1'b0;
    #2 rstn = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_eth_en", 32'(eth_en), 32'd0);
    chk("rst_ch_sel", 32'(ch_sel), 32'd0);
    chk("rst_flags", {29'd0, sof, eof, burst_abort}, 32'd0);
    @(posedge clk);
    #1;

    // single channel, uninterrupted burst
    full      = 4'b0001;
    eth_ready = 1'b1;
    push_burst(0, 4);
    rstn = 1'b1;
    expect_pat("t1", "IBBBBIII");
    full = '0;
    expect_pat("t1_idle", "II");

    // all channels full: rotate 0,1,2,3,0
    do_reset();
    full = 4'b1111;
    push_burst(0, 4);
    push_burst(1, 4);
    push_burst(2, 4);
    push_burst(3, 4);
    push_burst(0, 4);
    for (int b = 0; b < 5; b++) expect_pat($sformatf("t2_b%0d", b), "IBBBBIII");
    full = '0;
    expect_pat("t2_idle", "I");

    // sink stalls two cycles mid-burst
    do_reset();
    full = 4'b0001;
    push_burst(0, 4);
    expect_pat("t3a", "IB");
    eth_ready = 1'b0;
    expect_pat("t3b", "II");
    eth_ready = 1'b1;
    expect_pat("t3c", "BBBIII");
    full = '0;
    expect_pat("t3d", "I");

    // granted FIFO drains after two words: abort, then next channel
    do_reset();
    full = 4'b0011;
    push_burst(0, 2);
    push_abort();
    push_burst(1, 4);
    expect_pat("t4a", "IBB");
    empty = 4'b0001;
    expect_pat("t4b", "A");
    empty = '0;
    expect_pat("t4c", "IIIIBBBBIII");
    full = '0;
    expect_pat("t4d", "II");

    // only ch2 eligible; ch1 arrives mid-burst and waits, ch3 noise ignored
    do_reset();
    full = 4'b0100;
    push_burst(2, 4);
    push_burst(1, 4);
    expect_pat("t5a", "IB");
    full  = 4'b1110;
    empty = 4'b1001;
    expect_pat("t5b", "BBBIII");
    expect_pat("t5c", "IBBBBIII");
    full  = '0;
    empty = '0;
    expect_pat("t5d", "I");

    // reset mid-burst on ch2, then ch0 wins priority
    do_reset();
    full = 4'b0100;
    push_burst(2, 1);
    expect_pat("t6a", "IB");
    rstn = 1'b0;
    #1;
    chk("t6_rst_rd_en", 32'(rd_en), 32'd0);
    chk("t6_rst_eth_en", 32'(eth_en), 32'd0);
    chk("t6_rst_ch_sel", 32'(ch_sel), 32'd0);
    chk("t6_rst_flags", {29'd0, sof, eof, burst_abort}, 32'd0);
    full = 4'b0101;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push_burst(0, 4);
    expect_pat("t6b", "IBBBBIII");
    full = '0;
    expect_pat("t6c", "I");

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_burst_arbiter.md
ETH_BURST_ARBITER -- requirements
Module: eth_burst_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of ADC channel FIFOs sharing the Ethernet path (2..8).
REQ-002 SHALL have parameter BURST_LEN, default 1024, words read per granted burst.
REQ-003 SHALL have parameter GAP_LEN, default 2048, idle cycles enforced after every burst.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port full  input  NUM_CH  per-channel FIFO full flag.
REQ-007 SHALL have port empty  input  NUM_CH  per-channel FIFO empty flag.
REQ-008 SHALL have port eth_ready  input  1  Ethernet sink accepts a word this cycle.
REQ-009 SHALL have port rd_en  output  NUM_CH  per-channel FIFO read strobe, one-hot or zero.
REQ-010 SHALL have port eth_en  output  1  valid word presented to Ethernet sink.
REQ-011 SHALL have port ch_sel  output  clog2(NUM_CH)  channel currently granted; steers data mux.
REQ-012 SHALL have port sof  output  1  first word of a burst.
REQ-013 SHALL have port eof  output  1  last word of a full-length burst.
REQ-014 SHALL have port burst_abort  output  1  one-cycle pulse, burst ended early on empty.

Function
REQ-015 SHALL implement states IDLE, READ, GAP.
REQ-016 IDLE: eligible channel c = full[c] & ~empty[c]; SHALL grant first eligible channel in round-robin order starting at last_grant+1 (mod NUM_CH), register it in ch_sel, clear word counter, move to READ next cycle.
REQ-017 IDLE with no eligible channel SHALL remain IDLE; ch_sel holds previous value.
REQ-018 READ beat = READ & eth_ready & ~empty[ch_sel]; rd_en[ch_sel] and eth_en SHALL equal beat combinationally, all other rd_en bits 0.
REQ-019 Word counter SHALL increment by 1 only on a beat; eth_ready=0 stalls without penalty.
REQ-020 sof SHALL equal beat & (count==0); eof SHALL equal beat & (count==BURST_LEN-1).
REQ-021 On eof beat: state -> GAP, count cleared, last_grant <= ch_sel.
REQ-022 READ with empty[ch_sel]=1: no beat, burst_abort=1 that cycle, state -> GAP, count cleared, last_grant <= ch_sel; empty overrides a coincident final-word cycle (abort, no eof).
REQ-023 GAP: counter increments every cycle regardless of inputs; at count==GAP_LEN-1 state -> IDLE, count cleared.
REQ-024 Counter width SHALL be clog2(max(BURST_LEN,GAP_LEN)) bits; never wraps within a state.
REQ-025 full/empty changes on non-granted channels SHALL not affect READ or GAP.
REQ-026 Outputs rd_en, eth_en, sof, eof, burst_abort SHALL be 0 in IDLE and GAP.

Reset
REQ-027 rstn=0 SHALL asynchronously force state IDLE, count 0, ch_sel 0, last_grant NUM_CH-1 (channel 0 first priority), all outputs 0.
REQ-028 Reset asserted mid-READ SHALL abandon the burst immediately with no eof/abort pulse; operation resumes from IDLE after rstn rises.

Verification (BURST_LEN=4, GAP_LEN=3, NUM_CH=4 unless stated)
REQ-029 Ch0 full, nonempty, eth_ready=1 -> IDLE 1 cycle, 4 consecutive beats on rd_en[0], sof on beat 1, eof on beat 4, 3 GAP cycles, IDLE.
REQ-030 All channels full continuously -> grant order 0,1,2,3,0; each burst 4 beats separated by 3-cycle gaps.
REQ-031 eth_ready low on beats 2-3 for 2 cycles -> 4 beats total spread over 6 cycles, eof still on 4th beat.
REQ-032 empty[ch_sel] rises after beat 2 -> burst_abort one cycle, no eof, 3 GAP cycles, next grant goes to following channel.
REQ-033 Only ch2 eligible with last_grant=3 -> ch2 granted; ch1 becomes eligible during ch2 READ -> ch1 not served until after GAP.
REQ-034 rstn pulsed low mid-burst (beat 2) -> all outputs 0 same cycle, state IDLE, next grant ch0 if eligible.
